// File: rtl/datapath_ctrl_pkg.sv
// datapath_ctrl_pkg: opcodes, FS codes, states and CTRWRD field layout for datapath_ctrl.
package datapath_ctrl_pkg;
  typedef enum logic [2:0] {
    S_FETCH, S_EXEC, S_MEM, S_WB, S_BR, S_HALT
`ifdef DPC_BUS_TIMEOUT_EN
    , S_FAULT
`endif
  } state_t;
  typedef enum logic [1:0] {C_ALU, C_MEM, C_BR, C_HALT} op_class_t;
  localparam logic [3:0] OP_MOVA = 4'h0, OP_INC = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4, OP_OR = 4'h5, OP_XOR = 4'h6, OP_NOT = 4'h7;
  localparam logic [3:0] OP_LDI = 4'h8, OP_ADI = 4'h9, OP_LD = 4'hA, OP_ST = 4'hB;
  localparam logic [3:0] OP_BRZ = 4'hC, OP_BRN = 4'hD, OP_JMP = 4'hE, OP_HALT = 4'hF;
  localparam logic [3:0] FS_MOVA = 4'b0000, FS_INC = 4'b0001, FS_ADD = 4'b0010, FS_SUB = 4'b0101;
  localparam logic [3:0] FS_AND = 4'b1000, FS_OR = 4'b1001, FS_XOR = 4'b1010, FS_NOT = 4'b1011;
  localparam logic [3:0] FS_MOVB = 4'b1100;
  localparam int DA_LSB = 13, AA_LSB = 10, BA_LSB = 7, MB_BIT = 6, FS_LSB = 2, MD_BIT = 1, RW_BIT = 0;
  function automatic logic [3:0] alu_fs(input logic [3:0] op);
    case (op)
      OP_INC:  alu_fs = FS_INC;
      OP_ADD:  alu_fs = FS_ADD;
      OP_SUB:  alu_fs = FS_SUB;
      OP_AND:  alu_fs = FS_AND;
      OP_OR:   alu_fs = FS_OR;
      OP_XOR:  alu_fs = FS_XOR;
      OP_NOT:  alu_fs = FS_NOT;
      OP_LDI:  alu_fs = FS_MOVB;
      OP_ADI:  alu_fs = FS_ADD;
      default: alu_fs = FS_MOVA;
    endcase
  endfunction
endpackage

// File: rtl/datapath_ctrl_decode.sv
// dpc_decode: combinational instruction word -> CTRWRD template, Cin constant and op class.
module dpc_decode
  import datapath_ctrl_pkg::*;
(
  input  logic [15:0] i_ir,
  output logic [15:0] o_ctrwrd,
  output logic [15:0] o_cin,
  output op_class_t   o_cls
);
  logic [3:0] w_op;
  logic       w_imm;
  logic       w_alu;
  assign w_op  = i_ir[15:12];
  assign w_imm = (w_op == OP_LDI) || (w_op == OP_ADI);
  assign o_cls = (w_op == OP_HALT) ? C_HALT :
                 (w_op == OP_LD || w_op == OP_ST) ? C_MEM :
                 (w_op >= OP_BRZ) ? C_BR : C_ALU;
  assign w_alu = (o_cls == C_ALU);
  // Only writing ops carry DA and RW; branches present R[sa] through an FS=0000 pass.
  assign o_ctrwrd = (o_cls == C_HALT) ? 16'h0000 :
                    {w_alu ? i_ir[11:9] : 3'b000, i_ir[8:6], i_ir[5:3], w_imm,
                     w_alu ? alu_fs(w_op) : FS_MOVA, 1'b0, w_alu};
  assign o_cin = w_imm ? {10'b0, i_ir[5:0]} : 16'h0000;
endmodule

// File: rtl/datapath_ctrl.sv
// datapath_ctrl: multi-cycle fetch/exec/mem/branch sequencer for the 8x16 datapath.
// Optional DPC_BUS_TIMEOUT_EN adds a mem_ack wait counter and a FAULT state.
module datapath_ctrl
  import datapath_ctrl_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic [15:0] CTRWRD,
  output logic [15:0] Cin,
  output logic [15:0] Din,
  input  logic [15:0] Adrout,
  input  logic [15:0] Dout,
  input  logic        V,
  input  logic        C,
  input  logic        N,
  input  logic        Z,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        halted,
  output logic [15:0] pc
);
  state_t      r_state;
  op_class_t   r_cls;
  op_class_t   w_cls;
  logic [15:0] r_ir, r_pc, r_ctrwrd, r_cin, r_din, r_addr, r_wdata;
  logic [15:0] w_ctrwrd, w_cin, w_br_pc;
  logic        r_req, r_we, r_halted;
  logic        w_unused;
`ifdef DPC_BUS_TIMEOUT_EN
  logic [7:0]  r_wait;
  assign w_unused = V ^ C;
`else
  assign w_unused = ^{V, C, TIMEOUT};
`endif
  dpc_decode u_decode (.i_ir(mem_rdata), .o_ctrwrd(w_ctrwrd), .o_cin(w_cin), .o_cls(w_cls));
  assign w_br_pc = (r_ir[15:12] == OP_JMP) ? Adrout :
                   ((r_ir[15:12] == OP_BRZ && Z) || (r_ir[15:12] == OP_BRN && N)) ?
                   r_pc + {{10{r_ir[5]}}, r_ir[5:0]} : r_pc;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      r_state  <= S_FETCH;
      r_cls    <= C_ALU;
      r_ir     <= 16'h0000;
      r_pc     <= RESET_PC;
      r_ctrwrd <= 16'h0000;
      r_cin    <= 16'h0000;
      r_din    <= 16'h0000;
      r_addr   <= 16'h0000;
      r_wdata  <= 16'h0000;
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_halted <= 1'b0;
`ifdef DPC_BUS_TIMEOUT_EN
      r_wait   <= 8'd0;
`endif
    end else begin
`ifdef DPC_BUS_TIMEOUT_EN
      r_wait <= (r_req && !mem_ack) ? r_wait + 8'd1 : 8'd0;
      if (r_req && !mem_ack && r_wait == TIMEOUT - 8'd1) begin
        r_req    <= 1'b0;
        r_we     <= 1'b0;
        r_ctrwrd <= 16'h0000;
        r_halted <= 1'b1;
        r_state  <= S_FAULT;
      end else
`endif
      case (r_state)
        // Every fetch starts with req low so the cycle after any ack sees req deasserted.
        S_FETCH:
          if (!r_req) begin
            r_req  <= 1'b1;
            r_we   <= 1'b0;
            r_addr <= r_pc;
          end else if (mem_ack) begin
            r_req    <= 1'b0;
            r_ir     <= mem_rdata;
            r_pc     <= r_pc + 16'd1;
            r_ctrwrd <= w_ctrwrd;
            r_cin    <= w_cin;
            r_cls    <= w_cls;
            r_state  <= S_EXEC;
          end
        S_EXEC:
          case (r_cls)
            C_ALU: begin
              r_ctrwrd <= 16'h0000;
              r_state  <= S_FETCH;
            end
            C_MEM: begin
              r_req   <= 1'b1;
              r_we    <= (r_ir[15:12] == OP_ST);
              r_addr  <= Adrout;
              r_wdata <= Dout;
              r_state <= S_MEM;
            end
            C_BR: r_state <= S_BR;
            default: begin
              r_ctrwrd <= 16'h0000;
              r_halted <= 1'b1;
              r_state  <= S_HALT;
            end
          endcase
        S_MEM:
          if (mem_ack) begin
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_din    <= (r_ir[15:12] == OP_LD) ? mem_rdata : r_din;
            r_ctrwrd <= (r_ir[15:12] == OP_LD) ? {r_ir[11:9], r_ctrwrd[12:2], 2'b11} : 16'h0000;
            r_state  <= (r_ir[15:12] == OP_LD) ? S_WB : S_FETCH;
          end
        S_WB: begin
          r_ctrwrd <= 16'h0000;
          r_state  <= S_FETCH;
        end
        S_BR: begin
          r_pc     <= w_br_pc;
          r_ctrwrd <= 16'h0000;
          r_state  <= S_FETCH;
        end
        default: ;
      endcase
    end
  assign CTRWRD    = r_ctrwrd;
  assign Cin       = r_cin;
  assign Din       = r_din;
  assign mem_req   = r_req;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign halted    = r_halted;
  assign pc        = r_pc;
endmodule

// File: tb/tb_datapath_ctrl.sv
// tb_datapath_ctrl: directed self-checking bench for datapath_ctrl.
module tb_datapath_ctrl;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [15:0] CTRWRD, Cin, Din, mem_addr, mem_wdata, pc;
  logic [15:0] Adrout = 16'h0000, Dout = 16'h0000, mem_rdata = 16'h0000;
  logic        V = 1'b0, C = 1'b0, N = 1'b0, Z = 1'b0, mem_ack = 1'b0;
  logic        mem_req, mem_we, halted;
  int          checks = 0, errors = 0;
  int          hi;

  datapath_ctrl #(.RESET_PC(16'h0000), .TIMEOUT(8'd255)) dut (
    .CLK(CLK), .RESET(RESET), .CTRWRD(CTRWRD), .Cin(Cin), .Din(Din),
    .Adrout(Adrout), .Dout(Dout), .V(V), .C(C), .N(N), .Z(Z),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .halted(halted), .pc(pc)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a fetch request, checks its address, then acks after dly cycles.
  task automatic fetch(input logic [15:0] ins, input int dly, input logic [15:0] addr);
    int n = 0;
    while (!mem_req && n < 20) begin
      step();
      n++;
    end
    check("fetch_req", {15'b0, mem_req}, 16'h0001);
    check("fetch_we", {15'b0, mem_we}, 16'h0000);
    check("fetch_addr", mem_addr, addr);
    repeat (dly) step();
    mem_rdata = ins;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
  endtask

  initial begin
    repeat (2) step();
    check("rst_ctrwrd", CTRWRD, 16'h0000);
    check("rst_cin", Cin, 16'h0000);
    check("rst_din", Din, 16'h0000);
    check("rst_req", {15'b0, mem_req}, 16'h0000);
    check("rst_addr", mem_addr, 16'h0000);
    check("rst_halted", {15'b0, halted}, 16'h0000);
    check("rst_pc", pc, 16'h0000);
    RESET = 1'b0;
    // LDI R1,5
    fetch(16'h8205, 0, 16'h0000);
    check("ldi_ctrwrd", CTRWRD, 16'h2071);
    check("ldi_cin", Cin, 16'h0005);
    check("ldi_pc", pc, 16'h0001);
    step();
    check("post_exec_ctrwrd", CTRWRD, 16'h0000);
    // ADD R3,R1,R2 with a 3-cycle ack delay
    step();
    check("add_addr", mem_addr, 16'h0001);
    hi = 0;
    repeat (3) begin
      hi += int'(mem_req);
      step();
    end
    hi += int'(mem_req);
    mem_rdata = 16'h2650;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("add_req_cycles", 16'(hi), 16'd4);
    check("add_req_drop", {15'b0, mem_req}, 16'h0000);
    check("add_ctrwrd", CTRWRD, 16'h6509);
    check("add_cin", Cin, 16'h0000);
    check("add_pc", pc, 16'h0002);
    // ST M[R4]=R5 then LD R6=M[R4]
    Adrout = 16'h0040;
    Dout = 16'hBEEF;
    fetch(16'hB128, 0, 16'h0002);
    check("st_exec_ctrwrd", CTRWRD, 16'h1280);
    step();
    check("st_req", {15'b0, mem_req}, 16'h0001);
    check("st_we", {15'b0, mem_we}, 16'h0001);
    check("st_addr", mem_addr, 16'h0040);
    check("st_wdata", mem_wdata, 16'hBEEF);
    check("st_mem_ctrwrd", CTRWRD, 16'h1280);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("st_req_drop", {15'b0, mem_req}, 16'h0000);
    Dout = 16'h0000;
    fetch(16'hAD00, 0, 16'h0003);
    check("ld_exec_ctrwrd", CTRWRD, 16'h1000);
    step();
    check("ld_we", {15'b0, mem_we}, 16'h0000);
    check("ld_addr", mem_addr, 16'h0040);
    mem_rdata = 16'hBEEF;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("wb_ctrwrd", CTRWRD, 16'hD003);
    check("wb_din", Din, 16'hBEEF);
    step();
    check("post_wb_ctrwrd", CTRWRD, 16'h0000);
    // JMP R2 -> 0010, then BRZ taken / not taken, BRN taken
    Adrout = 16'h0010;
    fetch(16'hE080, 0, 16'h0004);
    check("jmp_ctrwrd", CTRWRD, 16'h0800);
    Z = 1'b1;
    fetch(16'hC07C, 0, 16'h0010);
    check("brz_rw", {15'b0, CTRWRD[0]}, 16'h0000);
    fetch(16'hE080, 0, 16'h000D);
    Z = 1'b0;
    fetch(16'hC07C, 0, 16'h0010);
    N = 1'b1;
    fetch(16'hD002, 0, 16'h0011);
    Adrout = 16'hFFFF;
    fetch(16'hE000, 0, 16'h0014);
    N = 1'b0;
    // INC at FFFF: PC wraps to 0000
    fetch(16'h1240, 0, 16'hFFFF);
    check("inc_ctrwrd", CTRWRD, 16'h2405);
    check("wrap_pc", pc, 16'h0000);
    // Reset in the middle of a load transfer
    Adrout = 16'h0080;
    fetch(16'hAD00, 0, 16'h0000);
    step();
    check("mem_req_before_rst", {15'b0, mem_req}, 16'h0001);
    check("mem_addr_before_rst", mem_addr, 16'h0080);
    RESET = 1'b1;
    #2;
    check("rst_async_req", {15'b0, mem_req}, 16'h0000);
    check("rst_async_pc", pc, 16'h0000);
    check("rst_async_ctrwrd", CTRWRD, 16'h0000);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    mem_rdata = 16'hF000;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("stray_ack_req", {15'b0, mem_req}, 16'h0001);
    check("stray_ack_pc", pc, 16'h0000);
    // HALT
    fetch(16'hF000, 0, 16'h0000);
    check("halt_exec_ctrwrd", CTRWRD, 16'h0000);
    check("halt_exec_halted", {15'b0, halted}, 16'h0000);
    step();
    check("halted", {15'b0, halted}, 16'h0001);
    hi = 0;
    repeat (20) begin
      hi += int'(mem_req);
      step();
    end
    check("halt_no_req", 16'(hi), 16'd0);
    check("halt_still", {15'b0, halted}, 16'h0001);
    check("halt_ctrwrd", CTRWRD, 16'h0000);
    check("halt_pc", pc, 16'h0001);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
